// File: rtl/gcd_stream_if.sv
// Handshake bundle between operand sources, the GCD engine and result consumers.
// master = source/consumer side, slave = engine side.
interface gcd_stream_if #(
  parameter int WIDTH  = 8,
  parameter int ITER_W = 6
);
  logic              in_valid;
  logic              in_ready;
  logic [WIDTH-1:0]  in_a;
  logic [WIDTH-1:0]  in_b;
  logic              out_valid;
  logic              out_ready;
  logic [WIDTH-1:0]  out_result;
  logic [ITER_W-1:0] out_iters;
  logic              busy;

  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_result, out_iters, busy
  );

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_result, out_iters, busy
  );
endinterface

// File: rtl/gcd_stream_unit.sv
// Binary (Stein) GCD engine with valid/ready or change-triggered start, and an iteration count.
// state | meaning: IDLE = waiting for a pair, RUN = one Stein step per cycle, DONE = result presented
module gcd_stream_unit #(
  parameter int WIDTH  = 8,
  parameter int ITER_W = 6,
  parameter int AUTO   = 0
) (
  input logic        clk,
  input logic        rst,
  gcd_stream_if.slave s
);
  localparam int K_W = $clog2(WIDTH) + 1;
  localparam logic [ITER_W-1:0] ITER_MAX = '1;
  localparam bit AUTO_MODE = (AUTO != 0);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t              state_q, state_nxt;
  logic [WIDTH-1:0]    a_q, a_nxt, b_q, b_nxt;
  logic [WIDTH-1:0]    res_q, res_nxt;
  logic [K_W-1:0]      k_q, k_nxt;
  logic [ITER_W-1:0]   iters_q, iters_nxt;
  logic [2*WIDTH-1:0]  last_q;
  logic                out_valid_q;
  logic [WIDTH-1:0]    out_result_q;
  logic [ITER_W-1:0]   out_iters_q;
  logic                start;

  // AUTO compares against the last accepted pair, so edits made while busy retrigger from IDLE
  assign start = (state_q == S_IDLE) &&
                 (AUTO_MODE ? ({s.in_a, s.in_b} != last_q) : s.in_valid);

  always_comb begin
    state_nxt = state_q;
    a_nxt     = a_q;
    b_nxt     = b_q;
    k_nxt     = k_q;
    iters_nxt = iters_q;
    res_nxt   = res_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          a_nxt     = s.in_a;
          b_nxt     = s.in_b;
          k_nxt     = '0;
          iters_nxt = '0;
          state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (a_q == '0 || b_q == '0) begin
          res_nxt   = (a_q | b_q) << k_q;
          state_nxt = S_DONE;
        end else if (a_q == b_q) begin
          res_nxt   = a_q << k_q;
          state_nxt = S_DONE;
        end else begin
          iters_nxt = (iters_q == ITER_MAX) ? iters_q : iters_q + ITER_W'(1);
          if (!a_q[0] && !b_q[0]) begin
            a_nxt = a_q >> 1;
            b_nxt = b_q >> 1;
            k_nxt = k_q + K_W'(1);
          end else if (!a_q[0]) begin
            a_nxt = a_q >> 1;
          end else if (!b_q[0]) begin
            b_nxt = b_q >> 1;
          end else if (a_q > b_q) begin
            a_nxt = (a_q - b_q) >> 1;
          end else begin
            b_nxt = (b_q - a_q) >> 1;
          end
        end
      end
      S_DONE: begin
        if (AUTO_MODE) begin
          if (out_valid_q) state_nxt = S_IDLE;
        end else if (out_valid_q && s.out_ready) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      a_q          <= '0;
      b_q          <= '0;
      k_q          <= '0;
      iters_q      <= '0;
      res_q        <= '0;
      last_q       <= '0;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_iters_q  <= '0;
    end else begin
      state_q <= state_nxt;
      a_q     <= a_nxt;
      b_q     <= b_nxt;
      k_q     <= k_nxt;
      iters_q <= iters_nxt;
      res_q   <= res_nxt;
      if (start) last_q <= {s.in_a, s.in_b};
      // First DONE cycle publishes the result; out_result then holds until the next completion
      if (state_q == S_DONE && !out_valid_q) begin
        out_valid_q  <= 1'b1;
        out_result_q <= res_q;
        out_iters_q  <= iters_q;
      end else if (state_q == S_DONE && state_nxt == S_IDLE) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign s.in_ready   = (state_q == S_IDLE);
  assign s.busy       = (state_q == S_RUN) || (state_q == S_DONE);
  assign s.out_valid  = out_valid_q;
  assign s.out_result = out_result_q;
  assign s.out_iters  = out_iters_q;
endmodule
